// File: rtl/set_bit_scanner_pkg.sv
// Shared types and constants for the set-bit scanner.
package set_bit_scanner_pkg;

    typedef enum logic {
        SCAN_IDLE,
        SCAN_ACTIVE
    } scan_state_t;

    localparam logic SCAN_LSB_FIRST = 1'b0;
    localparam logic SCAN_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_scan_pick.sv
// Combinational picker: index and one-hot of the lowest (or highest) set bit.
module bit_scan_pick
    import set_bit_scanner_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned IW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vector,
    input  logic             msb_first,
    output logic [IW-1:0]    index,
    output logic [WIDTH-1:0] onehot,
    output logic             found
);

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] onehot_r;
    logic [IW-1:0]    idx_r;
    logic             rev;

    assign rev = (msb_first == SCAN_MSB_FIRST);

    // MSB-first reuses the lowest-bit search on the bit-reversed vector,
    // then maps the result back into the original bit order.
    always_comb begin
        sel      = '0;
        onehot_r = '0;
        onehot   = '0;
        idx_r    = '0;
        index    = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sel[i] = rev ? vector[WIDTH-1-i] : vector[i];
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && sel[i]) begin
                found       = 1'b1;
                idx_r       = IW'(i);
                onehot_r[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            onehot[i] = rev ? onehot_r[WIDTH-1-i] : onehot_r[i];
        end
        if (found) begin
            index = rev ? (IW'(WIDTH - 1) - idx_r) : idx_r;
        end
    end

endmodule

// File: rtl/set_bit_scanner.sv
// Loads a vector through a handshake and streams the index of every set bit.
module set_bit_scanner
    import set_bit_scanner_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned IW = $clog2(WIDTH),
    localparam int unsigned CW = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_msb_first,
    input  logic             i_abort,
    output logic             o_idx_valid,
    input  logic             i_idx_ready,
    output logic [IW-1:0]    o_idx,
    output logic [WIDTH-1:0] o_idx_vector,
    output logic             o_idx_last,
    output logic [CW-1:0]    o_remaining,
    output logic             o_zero_load,
    output logic             o_busy
);

    scan_state_t      state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic             msb_q, msb_d;
    logic             zero_load_q, zero_load_d;
    logic [CW-1:0]    popcnt;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] pick_onehot;
    logic             pick_found;
    logic             busy;

    bit_scan_pick #(.WIDTH(WIDTH)) u_pick (
        .vector    (work_q),
        .msb_first (msb_q),
        .index     (pick_idx),
        .onehot    (pick_onehot),
        .found     (pick_found)
    );

    // Population count of the offered vector, loaded into the remaining counter.
    always_comb begin
        popcnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            popcnt = popcnt + CW'(i_data[i]);
        end
    end

    assign busy         = (state_q == SCAN_ACTIVE);
    assign o_busy       = busy;
    assign o_load_ready = (state_q == SCAN_IDLE);
    assign o_idx_valid  = busy && pick_found;
    assign o_idx        = busy ? pick_idx : '0;
    assign o_idx_vector = busy ? pick_onehot : '0;
    assign o_idx_last   = busy && (remaining_q == CW'(1));
    assign o_remaining  = remaining_q;
    assign o_zero_load  = zero_load_q;

    // Next-state: load in IDLE; emit, abort or finish in SCAN.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        msb_d       = msb_q;
        zero_load_d = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (i_load_valid) begin
                    work_d      = i_data;
                    msb_d       = i_msb_first;
                    remaining_d = popcnt;
                    if (|i_data) begin
                        state_d = SCAN_ACTIVE;
                    end else begin
                        zero_load_d = 1'b1;
                    end
                end
            end
            SCAN_ACTIVE: begin
                if (i_abort) begin
                    work_d      = '0;
                    remaining_d = '0;
                    state_d     = SCAN_IDLE;
                end else if (i_idx_ready) begin
                    work_d      = work_q & ~pick_onehot;
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = SCAN_IDLE;
                    end
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= SCAN_IDLE;
            work_q      <= '0;
            remaining_q <= '0;
            msb_q       <= SCAN_LSB_FIRST;
            zero_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            msb_q       <= msb_d;
            zero_load_q <= zero_load_d;
        end
    end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed self-checking bench for set_bit_scanner at WIDTH=8.
module tb_set_bit_scanner;

    localparam int unsigned WIDTH = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_load_valid;
    logic       o_load_ready;
    logic [7:0] i_data;
    logic       i_msb_first;
    logic       i_abort;
    logic       o_idx_valid;
    logic       i_idx_ready;
    logic [2:0] o_idx;
    logic [7:0] o_idx_vector;
    logic       o_idx_last;
    logic [3:0] o_remaining;
    logic       o_zero_load;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    set_bit_scanner #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_data       (i_data),
        .i_msb_first  (i_msb_first),
        .i_abort      (i_abort),
        .o_idx_valid  (o_idx_valid),
        .i_idx_ready  (i_idx_ready),
        .o_idx        (o_idx),
        .o_idx_vector (o_idx_vector),
        .o_idx_last   (o_idx_last),
        .o_remaining  (o_remaining),
        .o_zero_load  (o_zero_load),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 32'(o_load_ready), 32'd1);
        check({tag, "_valid"},      32'(o_idx_valid),  32'd0);
        check({tag, "_idx"},        32'(o_idx),        32'd0);
        check({tag, "_vec"},        32'(o_idx_vector), 32'd0);
        check({tag, "_last"},       32'(o_idx_last),   32'd0);
        check({tag, "_rem"},        32'(o_remaining),  32'd0);
        check({tag, "_zero"},       32'(o_zero_load),  32'd0);
        check({tag, "_busy"},       32'(o_busy),       32'd0);
    endtask

    // Offer one vector for one cycle; returns at the negedge after acceptance.
    task automatic load(input logic [7:0] d, input logic msb);
        i_load_valid = 1'b1;
        i_data       = d;
        i_msb_first  = msb;
        @(negedge i_clk);
        i_load_valid = 1'b0;
        i_data       = 8'h5A;
        i_msb_first  = ~msb;
    endtask

    task automatic beat(input string tag, input int idx, input int rem, input logic last);
        check({tag, "_valid"}, 32'(o_idx_valid),  32'd1);
        check({tag, "_idx"},   32'(o_idx),        32'(idx));
        check({tag, "_vec"},   32'(o_idx_vector), 32'(1) << idx);
        check({tag, "_rem"},   32'(o_remaining),  32'(rem));
        check({tag, "_last"},  32'(o_idx_last),   32'(last));
    endtask

    initial begin
        int e;
        int cyc;
        logic [3:0] pat;
        i_rst_n      = 1'b0;
        i_load_valid = 1'b0;
        i_data       = '0;
        i_msb_first  = 1'b0;
        i_abort      = 1'b0;
        i_idx_ready  = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("reset");

        // LSB-first 1010_0100
        load(8'hA4, 1'b0);
        beat("lsb0", 2, 3, 1'b0);
        @(negedge i_clk);
        beat("lsb1", 5, 2, 1'b0);
        @(negedge i_clk);
        beat("lsb2", 7, 1, 1'b1);
        @(negedge i_clk);
        check("lsb_done_valid", 32'(o_idx_valid), 32'd0);
        check("lsb_done_ready", 32'(o_load_ready), 32'd1);

        // MSB-first same vector
        load(8'hA4, 1'b1);
        beat("msb0", 7, 3, 1'b0);
        @(negedge i_clk);
        beat("msb1", 5, 2, 1'b0);
        @(negedge i_clk);
        beat("msb2", 2, 1, 1'b1);
        @(negedge i_clk);
        check("msb_done_valid", 32'(o_idx_valid), 32'd0);

        // All ones with ready pattern 1,0,0,1
        pat = 4'b1001;
        load(8'hFF, 1'b0);
        check("ff_rem_start", 32'(o_remaining), 32'd8);
        e = 0;
        cyc = 0;
        while (o_idx_valid && cyc < 64) begin
            beat("ff", e, 8 - e, (e == 7));
            i_idx_ready = pat[cyc % 4];
            if (i_idx_ready) e++;
            cyc++;
            @(negedge i_clk);
        end
        check("ff_beats", 32'(e), 32'd8);
        check("ff_done_valid", 32'(o_idx_valid), 32'd0);
        i_idx_ready = 1'b1;

        // Zero vector
        load(8'h00, 1'b0);
        check("zero_pulse", 32'(o_zero_load), 32'd1);
        check("zero_valid", 32'(o_idx_valid), 32'd0);
        check("zero_ready", 32'(o_load_ready), 32'd1);
        @(negedge i_clk);
        check("zero_pulse_end", 32'(o_zero_load), 32'd0);
        check("zero_valid2", 32'(o_idx_valid), 32'd0);

        // Abort while stalled
        i_idx_ready = 1'b0;
        load(8'h81, 1'b0);
        beat("ab0", 0, 2, 1'b0);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check_reset_outputs("ab_stall");

        // Abort beats a simultaneous handshake
        i_idx_ready = 1'b1;
        load(8'h81, 1'b1);
        beat("ab1", 7, 2, 1'b0);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check_reset_outputs("ab_hs");

        // Single set bit after abort
        load(8'h10, 1'b0);
        beat("single", 4, 1, 1'b1);
        @(negedge i_clk);
        check("single_done", 32'(o_idx_valid), 32'd0);

        // Abort in IDLE does not block a load
        i_abort = 1'b1;
        load(8'h02, 1'b1);
        i_abort = 1'b0;
        beat("idle_abort", 1, 1, 1'b1);
        @(negedge i_clk);

        // Asynchronous reset mid-scan
        load(8'h3C, 1'b0);
        beat("rst0", 2, 4, 1'b0);
        @(negedge i_clk);
        beat("rst1", 3, 3, 1'b0);
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            check("post_rst_valid", 32'(o_idx_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
